// File: rtl/video_position_counter_pkg.sv
// Shared video raster types: coordinate widths and position typedefs used by the
// position counter and by overlay blocks that address screen/font memories.
package video_position_counter_pkg;

  localparam int H_BITS_DEF = 12;
  localparam int V_BITS_DEF = 11;

  typedef logic [H_BITS_DEF-1:0] h_pos_t;
  typedef logic [V_BITS_DEF-1:0] v_pos_t;

endpackage : video_position_counter_pkg

// File: rtl/video_position_counter.sv
// Raster X/Y tracker for the pixel stream; counts show the pixel on the bus this cycle
// and advance on the edge that ends it. Pure observer: never stalls or alters the stream.
module video_position_counter
  import video_position_counter_pkg::*;
#(
  parameter int H_BITS = H_BITS_DEF,
  parameter int V_BITS = V_BITS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_vsync,
  input  logic              in_req,
  input  logic              in_eol,
  input  logic              in_eof,
  output logic [H_BITS-1:0] h_cntr,
  output logic [V_BITS-1:0] v_cntr
);

  logic [H_BITS-1:0] h_q, h_d;
  logic [V_BITS-1:0] v_q, v_d;

  // vsync wins over everything; eol/eof only mean something alongside in_req.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (in_vsync) begin
      h_d = '0;
      v_d = '0;
    end else if (in_req && in_eof) begin
      h_d = '0;
      v_d = '0;
    end else if (in_req && in_eol) begin
      h_d = '0;
      v_d = v_q + 1'b1;
    end else if (in_req) begin
      h_d = h_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_cntr = h_q;
  assign v_cntr = v_q;

endmodule : video_position_counter

// File: tb/tb_video_position_counter.sv
// Directed bench for video_position_counter: inputs change 1 ns after the rising
// edge, outputs are compared mid-cycle while they are stable.
module tb_video_position_counter;

  logic        clk;
  logic        reset;
  logic        in_vsync;
  logic        in_req;
  logic        in_eol;
  logic        in_eof;
  logic [11:0] h_cntr;
  logic [10:0] v_cntr;

  int n_checks = 0;
  int n_fail   = 0;

  video_position_counter #(.H_BITS(12), .V_BITS(11)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_vsync (in_vsync),
    .in_req   (in_req),
    .in_eol   (in_eol),
    .in_eof   (in_eof),
    .h_cntr   (h_cntr),
    .v_cntr   (v_cntr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_vsync = 1'b0;
    in_req   = 1'b0;
    in_eol   = 1'b0;
    in_eof   = 1'b0;
  endtask

  task automatic do_vsync();
    idle_inputs();
    in_vsync = 1'b1;
    tick();
    in_vsync = 1'b0;
  endtask

  // Moves to (h,v) from the origin: v end-of-line pixels then h ordinary pixels.
  task automatic goto_pos(input int h, input int v);
    do_vsync();
    for (int i = 0; i < v; i++) begin
      in_req = 1'b1; in_eol = 1'b1; tick();
    end
    in_eol = 1'b0;
    for (int i = 0; i < h; i++) begin
      in_req = 1'b1; tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_vsync = 1'($urandom_range(0, 1));
      in_req   = 1'($urandom_range(0, 1));
      in_eol   = 1'($urandom_range(0, 1));
      in_eof   = 1'($urandom_range(0, 1));
      tick();
      n_checks++;
      if (h_cntr !== 12'd0 || v_cntr !== 11'd0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: h=%0d v=%0d, required h=0 v=0", i, h_cntr, v_cntr);
      end
    end
    idle_inputs();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_req = 1'b1;
      n_checks++;
      if (h_cntr !== 12'(i) || v_cntr !== 11'd0) begin
        n_fail++;
        $display("FAIL reset_first_reqs px%0d: h=%0d v=%0d, required h=%0d v=0", i, h_cntr, v_cntr, i);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_frame_walk();
    do_vsync();
    for (int ln = 0; ln < 3; ln++) begin
      for (int px = 0; px < 4; px++) begin
        in_req = 1'b1;
        in_eol = (px == 3);
        in_eof = (px == 3) && (ln == 2);
        n_checks++;
        if (h_cntr !== 12'(px) || v_cntr !== 11'(ln)) begin
          n_fail++;
          $display("FAIL frame_walk (%0d,%0d): h=%0d v=%0d, required h=%0d v=%0d",
                   px, ln, h_cntr, v_cntr, px, ln);
        end
        tick();
      end
    end
    idle_inputs();
    n_checks++;
    if (h_cntr !== 12'd0 || v_cntr !== 11'd0) begin
      n_fail++;
      $display("FAIL frame_walk_end: h=%0d v=%0d, required h=0 v=0", h_cntr, v_cntr);
    end
  endtask

  task automatic test_gaps();
    // 1 = req cycle, 0 = idle cycle; expected h is the count of prior reqs.
    bit pattern [9] = '{1, 0, 0, 0, 0, 0, 1, 0, 1};
    int exp_h = 0;
    do_vsync();
    foreach (pattern[i]) begin
      in_req = pattern[i];
      n_checks++;
      if (h_cntr !== 12'(exp_h) || v_cntr !== 11'd0) begin
        n_fail++;
        $display("FAIL gaps cyc%0d: h=%0d v=%0d, required h=%0d v=0", i, h_cntr, v_cntr, exp_h);
      end
      tick();
      if (pattern[i]) exp_h++;
    end
    idle_inputs();
    n_checks++;
    if (h_cntr !== 12'd3) begin
      n_fail++;
      $display("FAIL gaps_end: h=%0d, required h=3", h_cntr);
    end
  endtask

  task automatic test_priority();
    goto_pos(7, 5);
    n_checks++;
    if (h_cntr !== 12'd7 || v_cntr !== 11'd5) begin
      n_fail++;
      $display("FAIL priority_setup: h=%0d v=%0d, required h=7 v=5", h_cntr, v_cntr);
    end
    in_vsync = 1'b1; in_req = 1'b1; in_eol = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (h_cntr !== 12'd0 || v_cntr !== 11'd0) begin
      n_fail++;
      $display("FAIL priority_vsync: h=%0d v=%0d, required h=0 v=0", h_cntr, v_cntr);
    end
  endtask

  task automatic test_qualification();
    goto_pos(9, 2);
    in_eol = 1'b1; in_eof = 1'b1;
    tick();
    tick();
    idle_inputs();
    n_checks++;
    if (h_cntr !== 12'd9 || v_cntr !== 11'd2) begin
      n_fail++;
      $display("FAIL qual_no_req: h=%0d v=%0d, required h=9 v=2", h_cntr, v_cntr);
    end
    // eol alone with req: next line, column reset
    in_req = 1'b1; in_eol = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (h_cntr !== 12'd0 || v_cntr !== 11'd3) begin
      n_fail++;
      $display("FAIL qual_eol: h=%0d v=%0d, required h=0 v=3", h_cntr, v_cntr);
    end
    in_req = 1'b1; tick(); tick();
    in_eol = 1'b1; in_eof = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (h_cntr !== 12'd0 || v_cntr !== 11'd0) begin
      n_fail++;
      $display("FAIL qual_eof_no_vsync: h=%0d v=%0d, required h=0 v=0", h_cntr, v_cntr);
    end
  endtask

  task automatic test_midline_events();
    goto_pos(6, 4);
    do_vsync();
    n_checks++;
    if (h_cntr !== 12'd0 || v_cntr !== 11'd0) begin
      n_fail++;
      $display("FAIL midline_vsync: h=%0d v=%0d, required h=0 v=0", h_cntr, v_cntr);
    end
    goto_pos(11, 3);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (h_cntr !== 12'd0 || v_cntr !== 11'd0) begin
      n_fail++;
      $display("FAIL async_reset: h=%0d v=%0d, required h=0 v=0", h_cntr, v_cntr);
    end
    tick();
    reset = 1'b0;
    in_req = 1'b1;
    n_checks++;
    if (h_cntr !== 12'd0 || v_cntr !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_origin: h=%0d v=%0d, required h=0 v=0", h_cntr, v_cntr);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (h_cntr !== 12'd1 || v_cntr !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_origin_next: h=%0d v=%0d, required h=1 v=0", h_cntr, v_cntr);
    end
  endtask

  task automatic test_wrap();
    do_vsync();
    in_req = 1'b1;
    for (int i = 0; i < 4095; i++) tick();
    n_checks++;
    if (h_cntr !== 12'd4095) begin
      n_fail++;
      $display("FAIL h_wrap_top: h=%0d, required h=4095", h_cntr);
    end
    tick();
    n_checks++;
    if (h_cntr !== 12'd0 || v_cntr !== 11'd0) begin
      n_fail++;
      $display("FAIL h_wrap: h=%0d v=%0d, required h=0 v=0", h_cntr, v_cntr);
    end
    in_eol = 1'b1;
    for (int i = 0; i < 2047; i++) tick();
    n_checks++;
    if (h_cntr !== 12'd0 || v_cntr !== 11'd2047) begin
      n_fail++;
      $display("FAIL v_wrap_top: h=%0d v=%0d, required h=0 v=2047", h_cntr, v_cntr);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (h_cntr !== 12'd0 || v_cntr !== 11'd0) begin
      n_fail++;
      $display("FAIL v_wrap: h=%0d v=%0d, required h=0 v=0", h_cntr, v_cntr);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_frame_walk();
    test_gaps();
    test_priority();
    test_qualification();
    test_midline_events();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_video_position_counter
